// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: result kinds, D-stage forward select codes,
// per-kind tnew constants and the stage tag record used by hazard logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    KIND_ALU = 2'b00,
    KIND_MEM = 2'b01,
    KIND_PC8 = 2'b10
  } kind_e;

  typedef enum logic [2:0] {
    FSEL_PC8_E = 3'b000,
    FSEL_PC8_M = 3'b001,
    FSEL_ALU_M = 3'b010,
    FSEL_RES_W = 3'b011,
    FSEL_RF    = 3'b100
  } fsel_e;

  localparam logic [1:0] TNEW_ALU = 2'd2;
  localparam logic [1:0] TNEW_MEM = 2'd3;
  localparam logic [1:0] TNEW_PC8 = 2'd1;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
    logic [1:0] kind;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{addr: 5'd0, tnew: 2'd0, kind: KIND_ALU};

  function automatic logic [1:0] kind_norm(input logic [1:0] kind);
    logic [1:0] k;
    case (kind)
      KIND_MEM: k = KIND_MEM;
      KIND_PC8: k = KIND_PC8;
      default:  k = KIND_ALU;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] tnew_of_kind(input logic [1:0] kind);
    logic [1:0] t;
    case (kind)
      KIND_MEM: t = TNEW_MEM;
      KIND_PC8: t = TNEW_PC8;
      default:  t = TNEW_ALU;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    logic [1:0] t;
    if (tnew == 2'd0) begin
      t = 2'd0;
    end else begin
      t = tnew - 2'd1;
    end
    return t;
  endfunction

  function automatic tag_t tag_age(input tag_t tag);
    tag_t t;
    t      = tag;
    t.tnew = tnew_dec(tag.tnew);
    return t;
  endfunction

endpackage

// File: rtl/fwd_operand_chk.sv
// Per-operand hazard check: forward select with E/M/W priority and stall
// request when the youngest producer is not ready in time.
module fwd_operand_chk
  import pipe_pkg::*;
(
  input  logic [4:0] i_reg,
  input  logic       i_use,
  input  logic [1:0] i_tuse,
  input  tag_t       i_tag_e,
  input  tag_t       i_tag_m,
  input  logic [4:0] i_addr_w,
  output logic       o_stall,
  output logic [2:0] o_fsel
);

  logic w_nonzero;
  logic w_hit_e;
  logic w_hit_m;
  logic w_hit_w;
  logic w_late_e;
  logic w_late_m;

  assign w_nonzero = (i_reg != 5'd0);
  assign w_hit_e   = w_nonzero && (i_tag_e.addr == i_reg);
  assign w_hit_m   = w_nonzero && (i_tag_m.addr == i_reg);
  assign w_hit_w   = w_nonzero && (i_addr_w == i_reg);
  assign w_late_e  = w_hit_e && (i_tuse < i_tag_e.tnew);
  assign w_late_m  = w_hit_m && (i_tuse < i_tag_m.tnew);

  // Any matching producer that cannot deliver by tuse freezes the operand.
  always_comb begin
    o_stall = 1'b0;
    if (i_use) begin
      o_stall = w_late_e || w_late_m;
    end else begin
      o_stall = 1'b0;
    end
  end

  // Youngest match wins; a not-ready youngest match falls back to the register file.
  always_comb begin
    o_fsel = FSEL_RF;
    if (w_hit_e) begin
      if ((i_tag_e.tnew == 2'd0) && (i_tag_e.kind == KIND_PC8)) begin
        o_fsel = FSEL_PC8_E;
      end else begin
        o_fsel = FSEL_RF;
      end
    end else if (w_hit_m) begin
      if (i_tag_m.tnew == 2'd0) begin
        if (i_tag_m.kind == KIND_PC8) begin
          o_fsel = FSEL_PC8_M;
        end else begin
          o_fsel = FSEL_ALU_M;
        end
      end else begin
        o_fsel = FSEL_RF;
      end
    end else if (w_hit_w) begin
      o_fsel = FSEL_RES_W;
    end else begin
      o_fsel = FSEL_RF;
    end
  end

endmodule

// File: rtl/fwd_stall_ctrl.sv
// D-stage forwarding/stall controller over E/M/W result tags.
// Optional stall-cycle counter enabled by macro FWD_STALL_CNT_EN.
module fwd_stall_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  a3_D,
  input  logic [1:0]  kind_D,
  output logic        stall,
  output logic [2:0]  FSel1_D,
  output logic [2:0]  FSel2_D,
  output logic [31:0] stall_cnt
);

  tag_t r_tag_e;
  tag_t r_tag_m;
  tag_t r_tag_w;
  tag_t w_tag_d;
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_unused_w;

  // E entry already carries one cycle of progress, hence tnew_D - 1.
  always_comb begin
    w_tag_d      = TAG_BUBBLE;
    w_tag_d.addr = a3_D;
    w_tag_d.kind = kind_norm(kind_D);
    w_tag_d.tnew = tnew_dec(tnew_of_kind(kind_norm(kind_D)));
  end

  // Tag pipeline: a stall inserts a bubble into E while M and W keep draining.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_e <= TAG_BUBBLE;
      r_tag_m <= TAG_BUBBLE;
      r_tag_w <= TAG_BUBBLE;
    end else begin
      if (stall) begin
        r_tag_e <= TAG_BUBBLE;
      end else begin
        r_tag_e <= w_tag_d;
      end
      r_tag_m <= tag_age(r_tag_e);
      r_tag_w <= tag_age(r_tag_m);
    end
  end

  fwd_operand_chk u_chk_rs (
    .i_reg    (rs_D),
    .i_use    (use_rs_D),
    .i_tuse   (tuse_rs_D),
    .i_tag_e  (r_tag_e),
    .i_tag_m  (r_tag_m),
    .i_addr_w (r_tag_w.addr),
    .o_stall  (w_stall_rs),
    .o_fsel   (FSel1_D)
  );

  fwd_operand_chk u_chk_rt (
    .i_reg    (rt_D),
    .i_use    (use_rt_D),
    .i_tuse   (tuse_rt_D),
    .i_tag_e  (r_tag_e),
    .i_tag_m  (r_tag_m),
    .i_addr_w (r_tag_w.addr),
    .o_stall  (w_stall_rt),
    .o_fsel   (FSel2_D)
  );

  assign stall = w_stall_rs || w_stall_rt;

  // W only needs its address for forwarding; timing fields are kept for visibility.
  assign w_unused_w = ^{r_tag_w.tnew, r_tag_w.kind};

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running stall counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
